// File: rtl/cache_write_buffer_pkg.sv
// rtl/cache_write_buffer_pkg.sv - shared widths and FSM state type for the write buffer
package cache_write_buffer_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } state_t;

endpackage

// File: rtl/cache_write_buffer_if.sv
// rtl/cache_write_buffer_if.sv - cache-side and memory-side signal bundle of the write buffer
interface cache_write_buffer_if #(
    parameter int ADDR_W = cache_write_buffer_pkg::DEF_ADDR_W,
    parameter int DATA_W = cache_write_buffer_pkg::DEF_DATA_W,
    parameter int LINE_W = cache_write_buffer_pkg::DEF_LINE_W
);
    // cache controller side
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_accept;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic [LINE_W-1:0] rd_data;
    logic              busy;
    // data memory side
    logic              mem_write_access;
    logic              mem_read_access;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_ready, mem_rdata,
        output wr_accept, rd_ready, rd_data, busy,
               mem_write_access, mem_read_access, mem_address, mem_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_ready, mem_rdata,
        input  wr_accept, rd_ready, rd_data, busy,
               mem_write_access, mem_read_access, mem_address, mem_wdata
    );
endinterface

// File: rtl/cache_write_buffer_fifo.sv
// rtl/cache_write_buffer_fifo.sv - in-order write entry FIFO with wrapping pointers and occupancy count
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_data = storage[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // storage is never reset; stale contents are unreachable while count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cache_write_buffer.sv
// rtl/cache_write_buffer.sv - write-through buffer draining to data memory ahead of line refills
module cache_write_buffer
    import cache_write_buffer_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_write_buffer_if.slave  bus
);
    localparam int ENT_W = ADDR_W + DATA_W;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              wa_q, wa_n;
    logic              ra_q, ra_n;
    logic              rdy_q, rdy_n;
    logic [LINE_W-1:0] rdata_q, rdata_n;

    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [ENT_W-1:0]        head;
    logic [$clog2(DEPTH):0]  count;

    // a full FIFO refuses writes even when the head pops in the same cycle
    assign push = bus.wr_req & ~full;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data ({bus.wr_addr, bus.wr_data}),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign bus.wr_accept        = push;
    assign bus.mem_write_access = wa_q;
    assign bus.mem_read_access  = ra_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_wdata        = wdata_q;
    assign bus.rd_ready         = rdy_q;
    assign bus.rd_data          = rdata_q;
    assign bus.busy             = (count != '0) || (state != IDLE);

    // state and registered memory-port outputs; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wa_q    <= 1'b0;
            ra_q    <= 1'b0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            wa_q    <= wa_n;
            ra_q    <= ra_n;
            rdy_q   <= rdy_n;
            rdata_q <= rdata_n;
        end
    end

    // drains take priority so a refill never overtakes a buffered write
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        wa_n    = wa_q;
        ra_n    = ra_q;
        rdy_n   = 1'b0;
        rdata_n = rdata_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_n = DRAIN;
                    addr_n  = head[ENT_W-1:DATA_W];
                    wdata_n = head[DATA_W-1:0];
                    wa_n    = 1'b1;
                end else if (bus.rd_req) begin
                    state_n = READ;
                    addr_n  = bus.rd_addr;
                    ra_n    = 1'b1;
                end
            end
            DRAIN: begin
                if (bus.mem_ready) begin
                    pop     = 1'b1;
                    wa_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            READ: begin
                if (bus.mem_ready) begin
                    rdata_n = bus.mem_rdata;
                    rdy_n   = 1'b1;
                    ra_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                wa_n    = 1'b0;
                ra_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// tb/tb_cache_write_buffer.sv - scoreboard bench for cache_write_buffer with randomized memory latency
module tb_cache_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LW    = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cache_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW), .LINE_W(LW)) bus ();

    cache_write_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .LINE_W (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int checks = 0;
    int errors = 0;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    int            rq_before[$];
    logic [LW-1:0] dq[$];
    int            accepted  = 0;
    int            completed = 0;
    int            rd_pulses = 0;

    bit hold    = 1'b0;
    bit spur    = 1'b0;
    int lat_min = 0;
    int lat_max = 3;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // memory model: answers each access after a random number of cycles
    initial begin : responder
        bit armed;
        int dly;
        armed = 1'b0;
        dly   = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (spur) begin
                bus.mem_ready = 1'b1;
                spur = 1'b0;
            end else if (!(bus.mem_write_access || bus.mem_read_access) || !rst_n) begin
                armed = 1'b0;
            end else if (!hold) begin
                if (!armed) begin
                    armed = 1'b1;
                    dly   = $urandom_range(lat_max, lat_min);
                end
                if (dly == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    armed = 1'b0;
                end else begin
                    dly--;
                end
            end
        end
    end

    // scoreboard monitor: checks acceptance, drain order, refill data and strobes
    always @(negedge clk) begin : monitor
        int  occ;
        wr_t e;
        if (rst_n) begin
            occ = accepted - completed;
            chk("strobe_exclusive", bus.mem_write_access & bus.mem_read_access, 0);
            chk("busy", bus.busy, (occ != 0) || bus.mem_write_access || bus.mem_read_access);
            if (bus.wr_req) begin
                chk("wr_accept", bus.wr_accept, occ < DEPTH);
                if (bus.wr_accept) begin
                    e.a = bus.wr_addr;
                    e.d = bus.wr_data;
                    wq.push_back(e);
                    accepted++;
                end
            end
            if (bus.mem_write_access && bus.mem_ready) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = wq.pop_front();
                    chk("mem_write_addr", bus.mem_address, e.a);
                    chk("mem_write_data", bus.mem_wdata, e.d);
                end
                completed++;
            end
            if (bus.mem_read_access && bus.mem_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    chk("mem_read_addr", bus.mem_address, rq.pop_front());
                    chk("read_after_writes", completed >= rq_before.pop_front(), 1);
                end
                dq.push_back(bus.mem_rdata);
            end
            if (bus.rd_ready) begin
                rd_pulses++;
                if (dq.size() == 0) begin
                    chk("unexpected_rd_ready", 1, 0);
                end else begin
                    chk("rd_data", bus.rd_data, dq.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.wr_req  = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wr_accept && n < 300);
        chk("push_accepted", bus.wr_accept, 1);
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int n;
        n = 0;
        while (bus.mem_read_access && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        rq.push_back(a);
        rq_before.push_back(accepted);
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.mem_read_access && n < 300);
        bus.rd_req = 1'b0;
        chk("read_started", bus.mem_read_access, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || wq.size() != 0 || dq.size() != 0) && n < 1000);
        chk("idle_reached", bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          c0;
        int          r0;
        logic [4:0]  acc;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;

        #1 rst_n = 1'b0;
        #2;
        chk("reset_mem_write_access", bus.mem_write_access, 0);
        chk("reset_mem_read_access", bus.mem_read_access, 0);
        chk("reset_rd_ready", bus.rd_ready, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_mem_address", bus.mem_address, 0);
        chk("reset_mem_wdata", bus.mem_wdata, 0);
        chk("reset_rd_data", bus.rd_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single write answered three cycles after the strobe
        lat_min = 3;
        lat_max = 3;
        c0 = completed;
        push(10'h005, 32'hDEADBEEF);
        wait_idle();
        chk("single_write_count", completed - c0, 1);
        lat_min = 0;

        // fill with memory stalled: fifth request must be refused
        hold = 1'b1;
        c0 = completed;
        for (int i = 0; i < 5; i++) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = AW'(10'h020 + i);
            bus.wr_data = $urandom;
            @(negedge clk);
            acc[i] = bus.wr_accept;
            @(posedge clk);
            #1;
        end
        bus.wr_req = 1'b0;
        chk("fill_accept_pattern", acc, 5'b01111);
        hold = 1'b0;
        wait_idle();
        chk("fill_write_count", completed - c0, 4);

        // refill queued behind two buffered writes
        hold = 1'b1;
        c0 = completed;
        r0 = rd_pulses;
        push(10'h101, $urandom);
        push(10'h102, $urandom);
        hold = 1'b0;
        do_read(10'h010);
        wait_idle();
        chk("raw_write_count", completed - c0, 2);
        chk("raw_rd_pulses", rd_pulses - r0, 1);

        // pointer wrap with drains interleaved
        c0 = completed;
        for (int i = 0; i < 10; i++) begin
            push(AW'($urandom), $urandom);
            if (i % 3 == 2) wait_idle();
        end
        wait_idle();
        chk("wrap_write_count", completed - c0, 10);

        // random mix of writes and refills
        c0 = completed;
        r0 = rd_pulses;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(9, 0) < 7) begin
                push(AW'($urandom), $urandom);
            end else begin
                do_read(AW'($urandom));
            end
        end
        wait_idle();
        chk("random_all_drained", completed, accepted);
        chk("random_no_pending_reads", rq.size(), 0);

        // reset in the middle of a refill
        hold = 1'b1;
        r0 = rd_pulses;
        do_read(10'h3A5);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_read_mem_read_access", bus.mem_read_access, 0);
        chk("rst_read_mem_write_access", bus.mem_write_access, 0);
        chk("rst_read_busy", bus.busy, 0);
        rq.delete();
        rq_before.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_read_no_rd_ready", rd_pulses - r0, 0);
        chk("rst_read_busy_after", bus.busy, 0);
        chk("rst_read_no_strobe", bus.mem_read_access, 0);

        // stray mem_ready while idle
        spur = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("spurious_busy", bus.busy, 0);
        chk("spurious_write_strobe", bus.mem_write_access, 0);
        chk("spurious_read_strobe", bus.mem_read_access, 0);
        c0 = completed;
        push(10'h2AA, 32'h12345678);
        wait_idle();
        chk("spurious_then_write_count", completed - c0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_write_buffer.md
CACHE_WRITE_BUFFER -- requirements
Module: cache_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 10, word address width.
REQ-003 SHALL have parameter DATA_W, default 32, write word width.
REQ-004 SHALL have parameter LINE_W, default 128, refill line width.
REQ-005 SHALL have a single clock: clk  in  1  rising-edge clock.
REQ-006 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have wr_req  in  1  write request from the cache controller (write-through).
REQ-008 SHALL have wr_addr  in  ADDR_W  write address.
REQ-009 SHALL have wr_data  in  DATA_W  write data.
REQ-010 SHALL have wr_accept  out  1  entry captured this cycle.
REQ-011 SHALL have rd_req  in  1  line refill request from the cache controller.
REQ-012 SHALL have rd_addr  in  ADDR_W  refill address.
REQ-013 SHALL have rd_ready  out  1  one-cycle pulse: rd_data valid.
REQ-014 SHALL have rd_data  out  LINE_W  refill line returned to the cache.
REQ-015 SHALL have busy  out  1  FIFO non-empty or memory access in flight.
REQ-016 SHALL have mem_write_access  out  1  write strobe to the data memory.
REQ-017 SHALL have mem_read_access  out  1  read strobe to the data memory.
REQ-018 SHALL have mem_address  out  ADDR_W  data-memory address.
REQ-019 SHALL have mem_wdata  out  DATA_W  data-memory write data.
REQ-020 SHALL have mem_ready  in  1  data memory done, one-cycle pulse.
REQ-021 SHALL have mem_rdata  in  LINE_W  data-memory line output.

Function
REQ-022 wr_accept SHALL be combinational: wr_req AND NOT full; an entry is pushed on that clk edge.
REQ-023 The FIFO SHALL be in-order, with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
REQ-024 When full, wr_accept SHALL be 0 even if a pop occurs that cycle; the same-cycle full push/pop case is not bypassed.
REQ-025 The FSM SHALL have exactly three states: IDLE, DRAIN and READ.
REQ-026 In IDLE, if the FIFO is non-empty, the FSM SHALL go to DRAIN; the head entry is latched into mem_address/mem_wdata, and mem_write_access=1 next cycle.
REQ-027 In IDLE, if the FIFO is empty and rd_req=1, the FSM SHALL latch rd_addr, go to READ, and assert mem_read_access=1.
REQ-028 Draining SHALL take priority over reads: rd_req is held pending (not latched) until the FIFO is empty, so no read-after-write hazard occurs.
REQ-029 In DRAIN, access SHALL be held stable until mem_ready; on mem_ready, pop the head, drop mem_write_access, and return to IDLE.
REQ-030 In READ, mem_read_access and mem_address SHALL be held until mem_ready; on mem_ready, rd_data<=mem_rdata, pulse rd_ready for 1 cycle, and go to IDLE.
REQ-031 Minimum latency SHALL be: write drain 1 cycle after push plus memory latency; read with an empty FIFO, rd_ready 1 cycle after the mem_ready edge.
REQ-032 A push while in DRAIN SHALL be allowed; a push on the cycle the last entry pops SHALL leave count unchanged.
REQ-033 busy SHALL be (count!=0) OR (state!=IDLE).
REQ-034 mem_read_access and mem_write_access SHALL never be asserted together.
REQ-035 A mem_ready received in IDLE SHALL be ignored.

Reset
REQ-036 Reset low SHALL asynchronously clear pointers, count, state to IDLE, mem_write_access, mem_read_access, rd_ready, mem_address, mem_wdata and rd_data to 0.
REQ-037 Reset mid-DRAIN or mid-READ SHALL discard the pending entry or request, with no retry after reset release.
REQ-038 FIFO storage SHALL need no reset; its contents are ignored while count==0.

Structure
REQ-039 A shared package SHALL hold the FSM state enum (IDLE/DRAIN/READ) and default widths ADDR_W=10, DATA_W=32, LINE_W=128.
REQ-040 The block SHALL contain one sub-module, wbuf_fifo (storage, pointers, count, full/empty); the FSM and memory port live in cache_write_buffer.

Verification
REQ-041 Single write: push addr 0x05, data 0xDEADBEEF; mem_ready 3 cycles later -> one mem_write_access with addr 0x05, data 0xDEADBEEF; busy falls after the pop.
REQ-042 Fill: 5 back-to-back wr_req with mem_ready withheld -> wr_accept 1,1,1,1,0; after releasing mem_ready, 4 memory writes occur in push order.
REQ-043 Read behind writes: 2 writes queued, then rd_req addr 0x10 -> both writes complete before mem_read_access asserts with addr 0x10; rd_ready pulses once with rd_data=mem_rdata.
REQ-044 Pointer wrap: 10 writes with interleaved drains -> memory sees all 10 in order, no loss or duplication.
REQ-045 Reset asserted mid-READ -> all strobes 0 immediately; no rd_ready after release; busy=0.
REQ-046 Spurious mem_ready in IDLE -> no state change and no pop.
